// File: rtl/matrix_alu_gen_if.sv
// matrix_alu_gen_if -- command/data bus between the host and matrix_alu_gen.
//   address[15:12] select, [11:8] immediate, [7:4] opcode, [3:0] register
//   nWrite / nRead  active-low strobes
//   ExeDataOut      matrix from the execution engine (N*N*W bits)
//   MatrixDataOut   registered result back to the execution engine
//   busy / done / err status from the ALU
// Element [i][j] of any matrix bus lives at bits (i*N+j)*W +: W.
interface matrix_alu_gen_if #(
    parameter int N = 4,
    parameter int W = 16
);
    logic [15:0]      address;
    logic             nWrite;
    logic             nRead;
    logic [N*N*W-1:0] ExeDataOut;
    logic [N*N*W-1:0] MatrixDataOut;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output address, nWrite, nRead, ExeDataOut,
        input  MatrixDataOut, busy, done, err
    );

    modport slave (
        input  address, nWrite, nRead, ExeDataOut,
        output MatrixDataOut, busy, done, err
    );
endinterface

// File: rtl/matrix_alu_gen.sv
// matrix_alu_gen -- N x N matrix ALU (MULTIPLY, ADD, SUBTRACT, TRANSPOSE,
// SCALE, SCALEIMM) controlled through address-mapped strobes.
// Ports:
//   Clk     rising-edge clock
//   nReset  asynchronous active-low reset
//   bus     matrix_alu_gen_if.slave (address, strobes, matrix buses, status)
// Register map (address[15:12] == 4'h2): reg 0/1 write src1/src2,
// reg 2 read result into MatrixDataOut, reg 3 start opcode address[7:4].
// Build option: define MATRIX_ALU_SAT_EN for signed elements with
// saturating ADD/SUBTRACT/SCALE/SCALEIMM/MULTIPLY; undefined gives unsigned
// wrap-around arithmetic with no clamp logic.
module matrix_alu_gen #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic             Clk,
    input  logic             nReset,
    matrix_alu_gen_if.slave  bus
);
    localparam int MW = N * N * W;
    localparam int RW = $clog2(N);
`ifdef MATRIX_ALU_SAT_EN
    // Wide enough to hold a full signed dot product without overflow.
    localparam int CW = 2 * W + $clog2(N);
    localparam logic [CW-1:0] SMAX = {{(CW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [CW-1:0] SMIN = {{(CW-W+1){1'b1}}, {(W-1){1'b0}}};
`else
    // Wrap mode keeps only the low W bits, which are identical whether the
    // dot product is accumulated at W bits or at 2W+clog2(N) bits.
    localparam int CW = W;
`endif

    localparam logic [3:0] OP_MUL = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2,
                           OP_TRN = 4'd3, OP_SCL = 4'd4, OP_SCI = 4'd5;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [3:0]      op_q, op_d, imm_q, imm_d;
    logic [MW-1:0]   src1_q, src1_d, src2_q, src2_d;
    logic [MW-1:0]   result_q, result_d, mdo_q, mdo_d;
    logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic            sel, wr, rd, both;
    logic [3:0]      reg_sel;
    logic [CW-1:0]   acc, scale_f;

    function automatic logic [W-1:0] el(input logic [MW-1:0] m, input int i, input int j);
        return m[(i*N+j)*W +: W];
    endfunction

    function automatic logic [CW-1:0] ext(input logic [W-1:0] x);
`ifdef MATRIX_ALU_SAT_EN
        return {{(CW-W){x[W-1]}}, x};
`else
        return x;
`endif
    endfunction

    function automatic logic [W-1:0] fin(input logic [CW-1:0] v);
`ifdef MATRIX_ALU_SAT_EN
        if ($signed(v) > $signed(SMAX))      return SMAX[W-1:0];
        else if ($signed(v) < $signed(SMIN)) return SMIN[W-1:0];
        else                                 return v[W-1:0];
`else
        return v;
`endif
    endfunction

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        op_d     = op_q;
        imm_d    = imm_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        result_d = result_q;
        mdo_d    = mdo_q;
        err_d    = err_q;
        acc      = '0;
        scale_f  = '0;

        sel     = (bus.address[15:12] == 4'h2);
        reg_sel = bus.address[3:0];
        wr      = sel && !bus.nWrite && bus.nRead;
        rd      = sel && !bus.nRead && bus.nWrite;
        both    = sel && !bus.nRead && !bus.nWrite;

        if (both) err_d = 1'b1;

        if (wr && (reg_sel == 4'd0 || reg_sel == 4'd1)) begin
            if (state_q == COMPUTE)    err_d  = 1'b1;
            else if (reg_sel == 4'd0)  src1_d = bus.ExeDataOut;
            else                       src2_d = bus.ExeDataOut;
        end

        // result_q is already final in DONE, so a read there sees the new value.
        if (rd && reg_sel == 4'd2) begin
            if (state_q == COMPUTE) err_d = 1'b1;
            else                    mdo_d = result_q;
        end

        if ((wr || rd) && reg_sel == 4'd3) begin
            if (state_q != IDLE || bus.address[7:4] > OP_SCI) begin
                err_d = 1'b1;
            end else begin
                state_d = COMPUTE;
                op_d    = bus.address[7:4];
                imm_d   = bus.address[11:8];
                row_d   = '0;
            end
        end

        case (state_q)
            COMPUTE: begin
                if (op_q == OP_MUL) begin
                    // One result row per cycle, row index row_q.
                    for (int j = 0; j < N; j++) begin
                        acc = '0;
                        for (int k = 0; k < N; k++)
                            acc = acc + ext(el(src1_q, int'(row_q), k)) * ext(el(src2_q, k, j));
                        result_d[(int'(row_q)*N+j)*W +: W] = fin(acc);
                    end
                    if (row_q == RW'(N-1)) state_d = DONE;
                    else                   row_d   = row_q + 1'b1;
                end else begin
                    scale_f = (op_q == OP_SCL) ? ext(el(src2_q, 0, 0))
                                               : {{(CW-4){1'b0}}, imm_q};
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            case (op_q)
                                OP_ADD:  acc = ext(el(src1_q, i, j)) + ext(el(src2_q, i, j));
                                OP_SUB:  acc = ext(el(src1_q, i, j)) - ext(el(src2_q, i, j));
                                default: acc = ext(el(src1_q, i, j)) * scale_f;
                            endcase
                            if (op_q == OP_TRN) result_d[(i*N+j)*W +: W] = el(src1_q, j, i);
                            else                result_d[(i*N+j)*W +: W] = fin(acc);
                        end
                    end
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase

        busy_d = (state_d == COMPUTE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= IDLE;
            row_q    <= '0;
            op_q     <= '0;
            imm_q    <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            result_q <= '0;
            mdo_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            op_q     <= op_d;
            imm_q    <= imm_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            result_q <= result_d;
            mdo_q    <= mdo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.MatrixDataOut = mdo_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
endmodule

// File: tb/tb_matrix_alu_gen.sv
// Testbench for matrix_alu_gen (N=4, W=16). Expected result matrices are
// queued when an operation is set up and popped when a result read lands.
module tb_matrix_alu_gen;
    logic clk;
    logic n_reset;
    int   total = 0;
    int   bad   = 0;
    logic [255:0] exp_q[$];
    logic [255:0] last_exp;

    matrix_alu_gen_if #(.N(4), .W(16)) bus ();

    matrix_alu_gen #(.N(4), .W(16)) dut (
        .Clk    (clk),
        .nReset (n_reset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.address = 16'h0000;
        bus.nWrite  = 1'b1;
        bus.nRead   = 1'b1;
    endtask

    task automatic wr_reg(input logic [3:0] sel, input logic [3:0] r, input logic [255:0] d);
        bus.address    = {sel, 4'h0, 4'h0, r};
        bus.ExeDataOut = d;
        bus.nWrite     = 1'b0;
        cycle();
        bus_idle();
    endtask

    task automatic start(input logic [3:0] op, input logic [3:0] imm);
        bus.address = {4'h2, imm, op, 4'h3};
        bus.nWrite  = 1'b0;
        cycle();
        bus_idle();
    endtask

    task automatic read_res();
        bus.address = 16'h2002;
        bus.nRead   = 1'b0;
        cycle();
        bus_idle();
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 256'd1, 256'd0);
        end else begin
            last_exp = exp_q.pop_front();
            chk("result", bus.MatrixDataOut, last_exp);
        end
    endtask

    // Called right after start(): counts busy cycles (bounded) then checks done.
    task automatic run_op(input int exp_busy, input bit read_in_done);
        int n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            cycle();
        end
        chk("busy_cycles", 256'(n), 256'(exp_busy));
        chk("done_high", 256'(bus.done), 256'd1);
        if (read_in_done) begin
            read_res();
        end else begin
            cycle();
            chk("done_pulse_end", 256'(bus.done), 256'd0);
            read_res();
        end
    endtask

    function automatic logic [255:0] fill(input logic [15:0] v);
        logic [255:0] m;
        for (int e = 0; e < 16; e++) m[e*16 +: 16] = v;
        return m;
    endfunction

    function automatic logic [255:0] rnd_mat();
        logic [255:0] m;
        for (int e = 0; e < 16; e++) m[e*16 +: 16] = 16'($urandom);
        return m;
    endfunction

    function automatic longint sv(input logic [255:0] m, input int i, input int j);
        logic [15:0] x;
        x = m[(i*4+j)*16 +: 16];
`ifdef MATRIX_ALU_SAT_EN
        return longint'($signed(x));
`else
        return longint'({48'd0, x});
`endif
    endfunction

    function automatic logic [15:0] clamp(input longint v);
`ifdef MATRIX_ALU_SAT_EN
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
`endif
        return v[15:0];
    endfunction

    function automatic logic [255:0] model(input int op, input logic [255:0] a,
                                           input logic [255:0] b, input logic [3:0] imm);
        logic [255:0] r = '0;
        longint v;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                v = 0;
                case (op)
                    0: for (int k = 0; k < 4; k++) v += sv(a, i, k) * sv(b, k, j);
                    1: v = sv(a, i, j) + sv(b, i, j);
                    2: v = sv(a, i, j) - sv(b, i, j);
                    4: v = sv(a, i, j) * sv(b, 0, 0);
                    5: v = sv(a, i, j) * longint'(imm);
                    default: v = 0;
                endcase
                if (op == 3) r[(i*4+j)*16 +: 16] = a[(j*4+i)*16 +: 16];
                else         r[(i*4+j)*16 +: 16] = clamp(v);
            end
        end
        return r;
    endfunction

    initial begin
        logic [255:0] ident, cnt, cnt_t, a, b;
        int ops[3];
        ops[0] = 2; ops[1] = 4; ops[2] = 0;
        ident = '0;
        for (int i = 0; i < 4; i++) begin
            ident[(i*4+i)*16 +: 16] = 16'd1;
            for (int j = 0; j < 4; j++) begin
                cnt[(i*4+j)*16 +: 16]   = 16'(i*4+j);
                cnt_t[(i*4+j)*16 +: 16] = 16'(j*4+i);
            end
        end
        last_exp = '0;
        bus_idle();
        bus.ExeDataOut = '0;
        n_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mdo", bus.MatrixDataOut, 256'd0);
        chk("rst_busy", 256'(bus.busy), 256'd0);
        chk("rst_done", 256'(bus.done), 256'd0);
        chk("rst_err", 256'(bus.err), 256'd0);
        #3 n_reset = 1'b1;
        cycle();

        // ADD 5 + 3
        wr_reg(4'h2, 4'd0, fill(16'd5));
        wr_reg(4'h2, 4'd1, fill(16'd3));
        exp_q.push_back(fill(16'd8));
        start(4'd1, 4'd0);
        run_op(1, 1'b0);

        // identity * counting matrix, then transpose
        wr_reg(4'h2, 4'd0, ident);
        wr_reg(4'h2, 4'd1, cnt);
        exp_q.push_back(cnt);
        start(4'd0, 4'd0);
        run_op(4, 1'b0);
        wr_reg(4'h2, 4'd0, cnt);
        exp_q.push_back(cnt_t);
        start(4'd3, 4'd0);
        run_op(1, 1'b0);

        // overflow boundary
`ifdef MATRIX_ALU_SAT_EN
        wr_reg(4'h2, 4'd0, fill(16'h7FFF));
        exp_q.push_back(fill(16'h7FFF));
`else
        wr_reg(4'h2, 4'd0, fill(16'hFFFF));
        exp_q.push_back(fill(16'h0000));
`endif
        wr_reg(4'h2, 4'd1, fill(16'd1));
        start(4'd1, 4'd0);
        run_op(1, 1'b0);

        // SCALEIMM by 3
        wr_reg(4'h2, 4'd0, fill(16'd7));
        exp_q.push_back(fill(16'd21));
        start(4'd5, 4'h3);
        run_op(1, 1'b0);

        // random SUB / SCALE / MULTIPLY; a write with the wrong select is ignored
        foreach (ops[n]) begin
            a = rnd_mat();
            b = rnd_mat();
            wr_reg(4'h2, 4'd0, a);
            wr_reg(4'h2, 4'd1, b);
            wr_reg(4'h1, 4'd0, rnd_mat());
            exp_q.push_back(model(ops[n], a, b, 4'd0));
            start(4'(ops[n]), 4'd0);
            run_op((ops[n] == 0) ? 4 : 1, ops[n] == 0);
        end
        chk("err_clean", 256'(bus.err), 256'd0);

        // illegal opcode: err, FSM stays idle, result unchanged
        start(4'd7, 4'd0);
        chk("badop_busy", 256'(bus.busy), 256'd0);
        chk("badop_err", 256'(bus.err), 256'd1);
        exp_q.push_back(last_exp);
        read_res();

        // src1 write during MULTIPLY is dropped
        a = rnd_mat();
        b = rnd_mat();
        wr_reg(4'h2, 4'd0, a);
        wr_reg(4'h2, 4'd1, b);
        exp_q.push_back(model(0, a, b, 4'd0));
        start(4'd0, 4'd0);
        wr_reg(4'h2, 4'd0, rnd_mat());
        run_op(3, 1'b0);

        // result read during COMPUTE is dropped
        start(4'd0, 4'd0);
        bus.address = 16'h2002;
        bus.nRead   = 1'b0;
        cycle();
        bus_idle();
        chk("read_while_busy", bus.MatrixDataOut, last_exp);
        exp_q.push_back(last_exp);
        run_op(3, 1'b0);

        // reset in the middle of MULTIPLY
        start(4'd0, 4'd0);
        cycle();
        n_reset = 1'b0;
        #1;
        chk("abort_mdo", bus.MatrixDataOut, 256'd0);
        chk("abort_busy", 256'(bus.busy), 256'd0);
        chk("abort_done", 256'(bus.done), 256'd0);
        chk("abort_err", 256'(bus.err), 256'd0);
        #7 n_reset = 1'b1;
        cycle();
        exp_q.push_back(256'd0);
        start(4'd1, 4'd0);
        run_op(1, 1'b0);

        // both strobes low together
        bus.address = 16'h2000;
        bus.nWrite  = 1'b0;
        bus.nRead   = 1'b0;
        cycle();
        bus_idle();
        chk("both_strobes_err", 256'(bus.err), 256'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
